// File: rtl/nn_result_axil_slave.sv
// AXI4-Lite slave exposing the classification result of the network output stage.
// Registers: CTRL (INT_EN, CLR), STATUS, RESULT (read pops), SCRATCH.
// Build option: define NN_RESULT_FIFO_EN to hold results in a 4-entry FIFO instead of a
// single result register.
module nn_result_axil_slave #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned RESULT_WIDTH = 8
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic [RESULT_WIDTH-1:0] result_data,
  input  logic                    result_valid,
  output logic                    intr
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  logic        aw_ready_q, bvalid_q, rvalid_q, intr_q, int_en_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q, scratch_q;

  logic        wr_acc, rd_acc, wr_unmapped, rd_unmapped;
  logic [1:0]  wr_word, rd_word;
  logic        ctrl_wr, clr, pop;
  logic        done, overrun;
  logic [2:0]  count;
  logic [31:0] result_rd, status_rd, rd_data_d;

  // Address bits [1:0] carry no information for word-wide registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wr_unmapped = |s_axi_awaddr[ADDR_WIDTH-1:4];
  assign rd_unmapped = |s_axi_araddr[ADDR_WIDTH-1:4];
  assign wr_word     = s_axi_awaddr[3:2];
  assign rd_word     = s_axi_araddr[3:2];

  // The ready pulse is registered, so the accept edge is the one where it is seen high.
  assign wr_acc  = aw_ready_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_acc  = s_axi_arvalid & ~rvalid_q;
  assign ctrl_wr = wr_acc & ~wr_unmapped & (wr_word == 2'd0) & s_axi_wstrb[0];
  assign clr     = ctrl_wr & s_axi_wdata[1];
  assign pop     = rd_acc & ~rd_unmapped & (rd_word == 2'd2);

`ifdef NN_RESULT_FIFO_EN
  logic [RESULT_WIDTH-1:0] fifo_q [4];
  logic [1:0]              wptr_q, rptr_q;
  logic [2:0]              cnt_q;
  logic                    ovr_q, fifo_pop, fifo_push;

  assign fifo_pop  = pop & (cnt_q != 3'd0);
  // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
  assign fifo_push = result_valid & ((cnt_q != 3'd4) | fifo_pop);

  // FIFO storage, pointers, occupancy and overrun flag; CLR empties, a same-cycle push wins.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
    end else if (clr) begin
      rptr_q <= '0;
      ovr_q  <= 1'b0;
      if (result_valid) begin
        fifo_q[0] <= result_data;
        wptr_q    <= 2'd1;
        cnt_q     <= 3'd1;
      end else begin
        wptr_q <= '0;
        cnt_q  <= '0;
      end
    end else begin
      if (fifo_push) begin
        fifo_q[wptr_q] <= result_data;
        wptr_q         <= wptr_q + 2'd1;
      end
      if (fifo_pop) rptr_q <= rptr_q + 2'd1;
      cnt_q <= cnt_q + 3'(fifo_push) - 3'(fifo_pop);
      if (result_valid && !fifo_push) ovr_q <= 1'b1;
    end
  end

  assign done    = (cnt_q != 3'd0);
  assign overrun = ovr_q;
  assign count   = cnt_q;

  // Head of FIFO, zero-extended; an empty FIFO reads as zero.
  always_comb begin
    result_rd = '0;
    if (done) result_rd[RESULT_WIDTH-1:0] = fifo_q[rptr_q];
  end
`else
  logic [RESULT_WIDTH-1:0] result_q, result_d;
  logic                    done_q, done_d, ovr_q, ovr_d;

  // Single result register: pop clears DONE, CLR wipes, a fresh result always wins.
  always_comb begin
    result_d = result_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    if (pop) done_d = 1'b0;
    if (clr) begin
      result_d = '0;
      done_d   = 1'b0;
      ovr_d    = 1'b0;
    end
    if (result_valid) begin
      result_d = result_data;
      done_d   = 1'b1;
      if (done_q && !pop && !clr) ovr_d = 1'b1;
    end
  end

  // Result register state.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      result_q <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign done    = done_q;
  assign overrun = ovr_q;
  assign count   = {2'b00, done_q};

  // Stored result, zero-extended.
  always_comb begin
    result_rd = '0;
    result_rd[RESULT_WIDTH-1:0] = result_q;
  end
`endif

  assign status_rd = {25'd0, count, 2'b00, overrun, done};

  // Read data mux; unmapped addresses read as zero.
  always_comb begin
    rd_data_d = '0;
    if (!rd_unmapped) begin
      unique case (rd_word)
        2'd0: rd_data_d = {31'd0, int_en_q};
        2'd1: rd_data_d = status_rd;
        2'd2: rd_data_d = result_rd;
        2'd3: rd_data_d = scratch_q;
      endcase
    end
  end

  // AXI handshake state, registered responses and interrupt.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      aw_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      rvalid_q   <= 1'b0;
      rresp_q    <= RespOkay;
      rdata_q    <= '0;
      intr_q     <= 1'b0;
    end else begin
      aw_ready_q <= s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~aw_ready_q;
      if (wr_acc) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_unmapped ? RespSlverr : RespOkay;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_d;
        rresp_q  <= rd_unmapped ? RespSlverr : RespOkay;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      intr_q <= done & int_en_q;
    end
  end

  // CTRL.INT_EN and byte-strobed SCRATCH writes.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      int_en_q  <= 1'b0;
      scratch_q <= '0;
    end else begin
      if (ctrl_wr) int_en_q <= s_axi_wdata[0];
      if (wr_acc && !wr_unmapped && (wr_word == 2'd3)) begin
        for (int b = 0; b < 4; b++) begin
          if (s_axi_wstrb[b]) scratch_q[8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  assign s_axi_awready = aw_ready_q;
  assign s_axi_wready  = aw_ready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = ~rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign intr          = intr_q;

endmodule

// File: tb/tb_nn_result_axil_slave.sv
// Directed bench for nn_result_axil_slave: register-access vector table plus hand-written
// sequences for the result path, holding responses and asynchronous reset.
module tb_nn_result_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid, intr;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  result_data = '0;
  logic        result_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nn_result_axil_slave #(.ADDR_WIDTH(32), .RESULT_WIDTH(8)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .result_data(result_data), .result_valid(result_valid), .intr(intr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    chk("wr_accept_in_time", 32'(n < 20), 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; bready = 1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("wr_resp_in_time", 32'(n < 20), 1);
    resp = bresp;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("rd_accept_in_time", 32'(n < 20), 1);
    @(posedge clk); #1;
    arvalid = 0; rready = 1;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rd_data_in_time", 32'(n < 20), 1);
    data = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 0;
  endtask

  // One-cycle result strobe.
  task automatic push(input logic [7:0] d);
    @(negedge clk);
    result_valid = 1; result_data = d;
    @(negedge clk);
    result_valid = 0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    chk(name, d, exp);
    chk({name, "_resp"}, 32'(r), 0);
  endtask

  // RESULT read accepted on the same edge as a new result strobe.
  task automatic pop_push(input logic [7:0] d, input logic [31:0] exp);
    @(negedge clk);
    chk("pp_arready", 32'(arready), 1);
    araddr = 32'h08; arvalid = 1; result_valid = 1; result_data = d;
    @(posedge clk); #1;
    arvalid = 0; result_valid = 0; rready = 1;
    chk("pp_rvalid", 32'(rvalid), 1);
    chk("pp_rdata", rdata, exp);
    @(posedge clk); #1;
    rready = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int n;

    vecs[0]  = '{1'b1, 32'h0C, 32'hA5A5_1234, 4'b0011, 32'h0, 2'b00};
    vecs[1]  = '{1'b0, 32'h0C, 32'h0, 4'b0000, 32'h0000_1234, 2'b00};
    vecs[2]  = '{1'b1, 32'h0C, 32'hFFFF_FFFF, 4'b1100, 32'h0, 2'b00};
    vecs[3]  = '{1'b0, 32'h0C, 32'h0, 4'b0000, 32'hFFFF_1234, 2'b00};
    vecs[4]  = '{1'b0, 32'h00, 32'h0, 4'b0000, 32'h0, 2'b00};
    vecs[5]  = '{1'b1, 32'h04, 32'hFF, 4'b1111, 32'h0, 2'b00};
    vecs[6]  = '{1'b0, 32'h04, 32'h0, 4'b0000, 32'h0, 2'b00};
    vecs[7]  = '{1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 2'b10};
    vecs[8]  = '{1'b1, 32'h14, 32'hDEAD, 4'b1111, 32'h0, 2'b10};
    vecs[9]  = '{1'b0, 32'h0C, 32'h0, 4'b0000, 32'hFFFF_1234, 2'b00};
    vecs[10] = '{1'b1, 32'h00, 32'h1, 4'b0000, 32'h0, 2'b00};
    vecs[11] = '{1'b0, 32'h00, 32'h0, 4'b0000, 32'h0, 2'b00};
    vecs[12] = '{1'b1, 32'h00, 32'h3, 4'b0001, 32'h0, 2'b00};
    vecs[13] = '{1'b0, 32'h00, 32'h0, 4'b0000, 32'h1, 2'b00};
    vecs[14] = '{1'b1, 32'h8000_000C, 32'h0, 4'b1111, 32'h0, 2'b10};
    vecs[15] = '{1'b0, 32'h8000_000C, 32'h0, 4'b0000, 32'h0, 2'b10};
    vecs[16] = '{1'b0, 32'h0C, 32'h0, 4'b0000, 32'hFFFF_1234, 2'b00};
    vecs[17] = '{1'b0, 32'h08, 32'h0, 4'b0000, 32'h0, 2'b00};

    // Reset state
    #1 rst_n = 0;
    #2;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_intr", 32'(intr), 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Register access table
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, d, r);
        chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end
    end

    // Interrupt follows DONE two edges after the strobe; pop drops it (INT_EN=1 from table)
    @(negedge clk);
    result_valid = 1; result_data = 8'h07;
    @(posedge clk); #1;
    result_valid = 0;
    chk("intr_lag1", 32'(intr), 0);
    @(posedge clk); #1;
    chk("intr_lag2", 32'(intr), 1);
    rd_chk("res_07", 32'h08, 32'h07);
    chk("intr_after_pop", 32'(intr), 0);
    rd_chk("status_after_pop", 32'h04, 32'h0);

    // Two results without a read
    push(8'h03);
    push(8'h05);
`ifdef NN_RESULT_FIFO_EN
    rd_chk("status_two", 32'h04, 32'h21);
    rd_chk("res_first", 32'h08, 32'h03);
    rd_chk("res_second", 32'h08, 32'h05);
    rd_chk("status_drained", 32'h04, 32'h00);
`else
    rd_chk("status_two", 32'h04, 32'h13);
    rd_chk("res_latest", 32'h08, 32'h05);
    rd_chk("status_popped", 32'h04, 32'h02);
`endif

    // CLR wipes DONE, OVERRUN and stored result (also INT_EN=0)
    axi_write(32'h00, 32'h2, 4'b0001, r);
    chk("clr_bresp", 32'(r), 0);
    rd_chk("status_clr", 32'h04, 32'h0);
    rd_chk("res_clr", 32'h08, 32'h0);

    // Pop and push on the same edge
    push(8'h09);
    pop_push(8'h0A, 32'h09);
    rd_chk("status_pp", 32'h04, 32'h11);
    rd_chk("res_pp", 32'h08, 32'h0A);

    // CLR and a new result on the same edge: result wins
    push(8'h01);
    push(8'h02);
    @(negedge clk);
    awaddr = 32'h00; wdata = 32'h2; wstrb = 4'b0001; awvalid = 1; wvalid = 1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("clrpush_accept_in_time", 32'(n < 20), 1);
    result_valid = 1; result_data = 8'h0B;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; result_valid = 0; bready = 1;
    chk("clrpush_bvalid", 32'(bvalid), 1);
    chk("clrpush_bresp", 32'(bresp), 0);
    @(posedge clk); #1;
    bready = 0;
    rd_chk("status_clrpush", 32'h04, 32'h11);
    rd_chk("res_clrpush", 32'h08, 32'h0B);

    // Raise intr so the reset check below is meaningful
    axi_write(32'h00, 32'h1, 4'b0001, r);
    push(8'h0C);
    repeat (2) @(posedge clk);
    #1 chk("intr_before_hold", 32'(intr), 1);

    // Hold responses with bready/rready low, a second write pending
    @(negedge clk);
    awaddr = 32'h0C; wdata = 32'h1122_3344; wstrb = 4'b1111; awvalid = 1; wvalid = 1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("hold_wr_accept_in_time", 32'(n < 20), 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    araddr = 32'h0C; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    awaddr = 32'h0C; wdata = 32'h0; awvalid = 1; wvalid = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_bvalid", 32'(bvalid), 1);
      chk("hold_bresp", 32'(bresp), 0);
      chk("hold_awready", 32'(awready), 0);
      chk("hold_rvalid", 32'(rvalid), 1);
      chk("hold_rdata", rdata, 32'h1122_3344);
      chk("hold_arready", 32'(arready), 0);
    end
    #2 rst_n = 0;
    #1;
    chk("arst_awready", 32'(awready), 0);
    chk("arst_wready", 32'(wready), 0);
    chk("arst_bvalid", 32'(bvalid), 0);
    chk("arst_rvalid", 32'(rvalid), 0);
    chk("arst_intr", 32'(intr), 0);
    chk("arst_bresp", 32'(bresp), 0);
    chk("arst_rresp", 32'(rresp), 0);
    chk("arst_rdata", rdata, 0);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_bvalid", 32'(bvalid), 0);
      chk("post_rst_rvalid", 32'(rvalid), 0);
    end
    rd_chk("post_rst_scratch", 32'h0C, 32'h0);
    rd_chk("post_rst_ctrl", 32'h00, 32'h0);
    rd_chk("post_rst_status", 32'h04, 32'h0);

`ifdef NN_RESULT_FIFO_EN
    // Overflow: fifth push dropped
    for (int i = 1; i <= 5; i++) push(8'(i));
    rd_chk("fifo_status_full", 32'h04, 32'h43);
    for (int i = 1; i <= 4; i++) rd_chk($sformatf("fifo_rd%0d", i), 32'h08, 32'(i));
    rd_chk("fifo_rd_empty", 32'h08, 32'h0);
    // Push and pop together while full: no overrun
    axi_write(32'h00, 32'h2, 4'b0001, r);
    for (int i = 6; i <= 9; i++) push(8'(i));
    pop_push(8'h0A, 32'h06);
    rd_chk("fifo_status_pp_full", 32'h04, 32'h41);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
